fifo_prog: RTL and testbench
============================

Name: fifo_prog

Overview:
Parametrised synchronous FIFO, the next generation of the team's fixed 32-bit FIFO.
- Generalised in data width and depth.
- Adds runtime-programmable almost-full/almost-empty thresholds, a selectable read mode (standard registered or first-word-fall-through) and a synchronous flush.
- Used as the general-purpose buffer between pipeline stages and bus adapters in a single clock domain.

Parameters:
- WIDTH, 32, data word width in bits (>=1).
- DEPTH, 16, number of entries (>=2, any integer; power of two not required).
- FWFT, 0, 0 = standard mode (registered read data, one-cycle latency); 1 = first-word-fall-through.
- CW, $clog2(DEPTH+1), width of count and threshold ports (derived, not overridden).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  synchronous clear of contents.
- wr_en  in  1  write request.
- data_in  in  WIDTH  write data.
- rd_en  in  1  read/pop request.
- data_out  out  WIDTH  read data.
- af_thresh  in  CW  almost-full threshold.
- ae_thresh  in  CW  almost-empty threshold.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= af_thresh.
- almost_empty  out  1  count <= ae_thresh.
- wr_ack  out  1  previous-cycle write accepted.
- valid  out  1  data_out valid.
- overflow  out  1  previous-cycle write rejected.
- underflow  out  1  previous-cycle read rejected.
- count  out  CW  current occupancy.

Behaviour:
- Reset (async assert, sync release):
  - wr_ptr, rd_ptr and count are 0; data_out is 0.
  - wr_ack, valid, overflow and underflow are 0; full is 0; empty is 1; almost_empty is 1.
  - almost_full is 1 only if af_thresh == 0.
- Pointers run 0..DEPTH-1 and wrap from DEPTH-1 to 0 explicitly, with no modulo power-of-two.
- full, empty, almost_full and almost_empty are combinational from the registered count and the threshold inputs; thresholds may change at any time.
- Write acceptance: wr_acc = wr_en & (!full | rd_acc).
- Read acceptance: rd_acc = rd_en & !empty.
- Full with simultaneous read and write: both are accepted and count is unchanged.
- Empty with simultaneous read and write: the read is rejected (underflow) and the write is accepted.
- count_next = count + wr_acc - rd_acc.
- wr_ack, overflow and underflow are registered, one cycle after the request:
  - wr_ack = wr_acc.
  - overflow = wr_en & !wr_acc.
  - underflow = rd_en & !rd_acc.
- Standard mode (FWFT=0):
  - On rd_acc, data_out <= mem[rd_ptr] and valid = 1 in the next cycle only.
  - Otherwise valid = 0 and data_out holds its last value.
- FWFT mode (FWFT=1):
  - data_out = mem[rd_ptr] combinationally; valid = !empty.
  - rd_en acts as a pop (acknowledge of the displayed word).
  - A word written into an empty FIFO is visible on data_out the cycle after the write.
- Flush:
  - Has priority over wr_en/rd_en. Pointers and count become 0 next cycle.
  - wr_ack, overflow, underflow and valid are 0 next cycle.
  - Memory contents are not cleared. Standard-mode data_out holds.
- Reset mid-operation discards all contents; no partial state survives.
- Memory is a register array; there are no RAM inference requirements.

Decomposition:
- Package fifo_pkg holds:
  - constants FIFO_MODE_STD = 0 and FIFO_MODE_FWFT = 1;
  - a ptr_inc(ptr, depth) function implementing the wrap rule.
- Sub-module fifo_regfile contains the storage:
  - parameters WIDTH and DEPTH;
  - one synchronous write port (we, waddr, wdata) and one combinational read port (raddr, rdata).
- fifo_prog contains the pointers, count, flags and mode logic.

Test Plan:
- All tests use WIDTH=16, DEPTH=6 unless stated.
- Fill/wrap:
  - Write 0x0001..0x0006, then read all six. Expect full=1, count=6, wr_ack each cycle.
  - Reads return 0x0001..0x0006 in order, each with valid=1 one cycle after rd_en; then empty=1.
  - Repeat twice more to exercise pointer wrap at 5 -> 0.
- Overflow/underflow:
  - wr_en when full -> overflow=1 next cycle, count stays 6, stored data unchanged.
  - rd_en when empty -> underflow=1 next cycle, valid=0.
- Simultaneous operations:
  - At count=6, wr_en and rd_en together -> wr_ack=1, no overflow, count=6.
  - At count=0, wr_en and rd_en together -> underflow=1, wr_ack=1, count=1.
- Thresholds:
  - af_thresh=4, ae_thresh=1. Stepping count 0..6 gives almost_empty=1 at counts 0–1 and almost_full=1 at counts 4–6.
  - Changing af_thresh to 2 at count=3 raises almost_full in the same cycle.
- FWFT=1:
  - Write 0xBEEF to an empty FIFO -> next cycle valid=1, data_out=0xBEEF with no rd_en.
  - Pop -> valid=0, empty=1.
- Flush and reset:
  - At count=4, flush together with wr_en -> next cycle count=0, empty=1, wr_ack=0.
  - rst asserted mid-burst -> all outputs at their reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the programmable FIFO.
//   FIFO_MODE_STD  : registered read data, one-cycle read latency.
//   FIFO_MODE_FWFT : first-word-fall-through, head word shown combinationally.
//   ptr_inc        : advance a pointer over 0..depth-1 with an explicit wrap,
//                    so depth does not have to be a power of two.
package fifo_pkg;

  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  function automatic logic [31:0] ptr_inc(input logic [31:0] ptr, input logic [31:0] depth);
    return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/fifo_regfile.sv
// Storage array for the programmable FIFO.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset (clears every entry)
//   we/waddr/wdata : synchronous write port
//   raddr/rdata  : combinational read port
module fifo_regfile #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Clearing on reset means nothing written before a reset can ever be
  // observed afterwards, including on the fall-through read path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/fifo_prog.sv
// Parametrised single-clock FIFO with programmable almost-full/almost-empty
// thresholds, selectable read mode and synchronous flush.
// Ports:
//   clk, rst               : clock, asynchronous active-high reset
//   flush                  : synchronous clear of pointers/count (wins over wr_en/rd_en)
//   wr_en, data_in         : write request and data
//   rd_en, data_out, valid : read/pop request, read data and its qualifier
//   af_thresh, ae_thresh   : almost-full / almost-empty thresholds (may change anytime)
//   full, empty, almost_full, almost_empty : combinational from count and thresholds
//   wr_ack, overflow, underflow            : registered outcome of last cycle's requests
//   count                  : current occupancy
// Handshake: a write is taken when wr_en is high and the FIFO is not full, or
// a read is taken in the same cycle; a read is taken when rd_en is high and
// the FIFO is not empty. Rejected requests are reported one cycle later.
module fifo_prog #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 16,
  parameter  int FWFT  = 0,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] data_in,
  input  logic             rd_en,
  output logic [WIDTH-1:0] data_out,
  input  logic [CW-1:0]    af_thresh,
  input  logic [CW-1:0]    ae_thresh,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic             wr_ack,
  output logic             valid,
  output logic             overflow,
  output logic             underflow,
  output logic [CW-1:0]    count
);
  import fifo_pkg::*;

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             wr_ack_q, wr_ack_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] dout_q, dout_d;

  logic             wr_acc, rd_acc, mem_we;
  logic [WIDTH-1:0] rdata;

  assign full         = (count_q == CW'(DEPTH));
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= af_thresh);
  assign almost_empty = (count_q <= ae_thresh);

  // A read frees a slot in the same cycle, so a full FIFO still takes a
  // write alongside a read; an empty FIFO never serves a read.
  assign rd_acc = rd_en & ~empty;
  assign wr_acc = wr_en & (~full | rd_acc);
  assign mem_we = wr_acc & ~flush;

  fifo_regfile #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_regfile (
    .clk   (clk),
    .rst   (rst),
    .we    (mem_we),
    .waddr (wr_ptr_q),
    .wdata (data_in),
    .raddr (rd_ptr_q),
    .rdata (rdata)
  );

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    wr_ack_d    = 1'b0;
    overflow_d  = 1'b0;
    underflow_d = 1'b0;
    valid_d     = 1'b0;
    dout_d      = dout_q;
    if (flush) begin
      // Contents stay in the array; only the bookkeeping is cleared.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_acc) wr_ptr_d = AW'(ptr_inc(32'(wr_ptr_q), 32'(DEPTH)));
      if (rd_acc) rd_ptr_d = AW'(ptr_inc(32'(rd_ptr_q), 32'(DEPTH)));
      count_d     = count_q + CW'(wr_acc) - CW'(rd_acc);
      wr_ack_d    = wr_acc;
      overflow_d  = wr_en & ~wr_acc;
      underflow_d = rd_en & ~rd_acc;
      valid_d     = rd_acc;
      if (rd_acc) dout_d = rdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      wr_ack_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      valid_q     <= 1'b0;
      dout_q      <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      wr_ack_q    <= wr_ack_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      valid_q     <= valid_d;
      dout_q      <= dout_d;
    end
  end

  assign wr_ack    = wr_ack_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
  assign count     = count_q;

  // Fall-through mode shows the head word directly; standard mode presents
  // the word captured on the accepted read, qualified for one cycle.
  generate
    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
      assign data_out = rdata;
      assign valid    = ~empty;
    end else begin : g_std
      assign data_out = dout_q;
      assign valid    = valid_q;
    end
  endgenerate

endmodule

// File: tb/tb_fifo_prog.sv
module tb_fifo_prog;
  localparam int W  = 16;
  localparam int D  = 6;
  localparam int CW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CW-1:0] af_thresh = CW'(4);
  logic [CW-1:0] ae_thresh = CW'(1);

  // standard-mode instance
  logic          flush = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
  logic [W-1:0]  data_in = '0, data_out;
  logic          full, empty, almost_full, almost_empty;
  logic          wr_ack, valid, overflow, underflow;
  logic [CW-1:0] count;

  // fall-through instance
  logic          f_flush = 1'b0, f_wr_en = 1'b0, f_rd_en = 1'b0;
  logic [W-1:0]  f_data_in = '0, f_data_out;
  logic          f_full, f_empty, f_almost_full, f_almost_empty;
  logic          f_wr_ack, f_valid, f_overflow, f_underflow;
  logic [CW-1:0] f_count;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];

  fifo_prog #(.WIDTH(W), .DEPTH(D), .FWFT(0)) dut (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .data_in(data_in),
    .rd_en(rd_en), .data_out(data_out), .af_thresh(af_thresh), .ae_thresh(ae_thresh),
    .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .wr_ack(wr_ack), .valid(valid), .overflow(overflow), .underflow(underflow),
    .count(count)
  );

  fifo_prog #(.WIDTH(W), .DEPTH(D), .FWFT(1)) dut_f (
    .clk(clk), .rst(rst), .flush(f_flush), .wr_en(f_wr_en), .data_in(f_data_in),
    .rd_en(f_rd_en), .data_out(f_data_out), .af_thresh(af_thresh), .ae_thresh(ae_thresh),
    .full(f_full), .empty(f_empty), .almost_full(f_almost_full), .almost_empty(f_almost_empty),
    .wr_ack(f_wr_ack), .valid(f_valid), .overflow(f_overflow), .underflow(f_underflow),
    .count(f_count)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, act=running exp=finished");
    $fatal(1, "watchdog");
  end

  // helpers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: act=0x%0h exp=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // drivers
  task automatic push_word(input logic [W-1:0] d);
    wr_en = 1'b1; data_in = d; rd_en = 1'b0;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic pop_word(input logic [W-1:0] expd);
    exp_q.push_back(expd);
    rd_en = 1'b1; wr_en = 1'b0;
    tick();
    rd_en = 1'b0;
  endtask

  // scoreboard monitor: every valid word on the standard instance is checked
  // against the oldest expected word
  always @(negedge clk) begin
    if (!rst && valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: act=0x%0h exp=no word pending at %0t", data_out, $time);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check("sb_data", 32'(data_out), 32'(e));
      end
    end
  end

  initial begin
    // reset state
    #2;
    check("rst_count", 32'(count), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_full", 32'(full), 0);
    check("rst_ae", 32'(almost_empty), 1);
    check("rst_af", 32'(almost_full), 0);
    check("rst_valid", 32'(valid), 0);
    check("rst_wr_ack", 32'(wr_ack), 0);
    check("rst_dout", 32'(data_out), 0);
    af_thresh = '0;
    #1;
    check("rst_af_zero_thresh", 32'(almost_full), 1);
    af_thresh = CW'(4);
    tick();
    rst = 1'b0;
    tick();

    // fill / drain three times to wrap the pointers
    for (int r = 0; r < 3; r++) begin
      for (int i = 1; i <= D; i++) begin
        push_word(W'((r << 8) | i));
        check("fill_wr_ack", 32'(wr_ack), 1);
        check("fill_count", 32'(count), 32'(i));
        if (r == 0) begin
          check("thr_ae", 32'(almost_empty), (i <= 1) ? 1 : 0);
          check("thr_af", 32'(almost_full), (i >= 4) ? 1 : 0);
        end
      end
      check("fill_full", 32'(full), 1);
      for (int i = 1; i <= D; i++) begin
        exp_q.push_back(W'((r << 8) | i));
        rd_en = 1'b1;
        tick();
      end
      rd_en = 1'b0;
      tick();
      check("drain_empty", 32'(empty), 1);
      check("drain_valid_low", 32'(valid), 0);
      check("drain_ae", 32'(almost_empty), 1);
    end

    // overflow, then simultaneous read+write while full
    for (int i = 1; i <= D; i++) push_word(W'(16'h0100 + i));
    push_word(16'hDEAD);
    check("ovf_flag", 32'(overflow), 1);
    check("ovf_wr_ack", 32'(wr_ack), 0);
    check("ovf_count", 32'(count), 6);
    exp_q.push_back(16'h0101);
    wr_en = 1'b1; data_in = 16'h0777; rd_en = 1'b1;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    check("full_rw_wr_ack", 32'(wr_ack), 1);
    check("full_rw_ovf", 32'(overflow), 0);
    check("full_rw_count", 32'(count), 6);
    for (int i = 2; i <= D; i++) pop_word(W'(16'h0100 + i));
    pop_word(16'h0777);
    tick();
    check("ovf_drain_empty", 32'(empty), 1);

    // underflow, then simultaneous read+write while empty
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("udf_flag", 32'(underflow), 1);
    check("udf_valid", 32'(valid), 0);
    wr_en = 1'b1; data_in = 16'h0ABC; rd_en = 1'b1;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    check("empty_rw_udf", 32'(underflow), 1);
    check("empty_rw_wr_ack", 32'(wr_ack), 1);
    check("empty_rw_count", 32'(count), 1);
    pop_word(16'h0ABC);
    tick();

    // threshold change takes effect without a clock edge
    for (int i = 1; i <= 3; i++) push_word(W'(16'h0200 + i));
    check("thr_af_at3", 32'(almost_full), 0);
    af_thresh = CW'(2);
    #1;
    check("thr_af_change", 32'(almost_full), 1);
    af_thresh = CW'(4);
    push_word(16'h0204);

    // flush with a concurrent write
    flush = 1'b1; wr_en = 1'b1; data_in = 16'h0F0F;
    tick();
    flush = 1'b0; wr_en = 1'b0;
    check("flush_count", 32'(count), 0);
    check("flush_empty", 32'(empty), 1);
    check("flush_wr_ack", 32'(wr_ack), 0);
    check("flush_valid", 32'(valid), 0);
    check("flush_dout_hold", 32'(data_out), 32'h0ABC);
    push_word(16'h1234);
    pop_word(16'h1234);
    tick();

    // asynchronous reset in the middle of a burst
    for (int i = 1; i <= 3; i++) push_word(W'(16'h0300 + i));
    wr_en = 1'b1; data_in = 16'h0304; rd_en = 1'b1;
    tick();
    #1;
    rst = 1'b1;
    #1;
    check("arst_count", 32'(count), 0);
    check("arst_empty", 32'(empty), 1);
    check("arst_wr_ack", 32'(wr_ack), 0);
    check("arst_valid", 32'(valid), 0);
    check("arst_dout", 32'(data_out), 0);
    check("arst_af", 32'(almost_full), 0);
    wr_en = 1'b0; rd_en = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    // fall-through mode
    check("fwft_rst_valid", 32'(f_valid), 0);
    check("fwft_rst_dout", 32'(f_data_out), 0);
    f_wr_en = 1'b1; f_data_in = 16'hBEEF;
    tick();
    f_wr_en = 1'b0;
    check("fwft_valid", 32'(f_valid), 1);
    check("fwft_dout", 32'(f_data_out), 32'hBEEF);
    f_wr_en = 1'b1; f_data_in = 16'h5A5A;
    tick();
    f_wr_en = 1'b0;
    check("fwft_head_stays", 32'(f_data_out), 32'hBEEF);
    f_rd_en = 1'b1;
    tick();
    check("fwft_next", 32'(f_data_out), 32'h5A5A);
    check("fwft_valid2", 32'(f_valid), 1);
    tick();
    f_rd_en = 1'b0;
    check("fwft_pop_valid", 32'(f_valid), 0);
    check("fwft_pop_empty", 32'(f_empty), 1);

    // final report
    tick();
    check("sb_drained", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
